// File: rtl/ext_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// ext_mem_responder_pkg : size codes, FSM encodings and burst address helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ext_mem_responder_pkg;

  localparam logic [4:0] SZ_BURST16 = 5'd15;
  localparam logic [4:0] SZ_BURST32 = 5'd31;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RDCMD  = 3'd1;
  localparam logic [2:0] ST_RDWAIT = 3'd2;
  localparam logic [2:0] ST_ERRREP = 3'd3;
  localparam logic [2:0] ST_WRCMD  = 3'd4;
  localparam logic [2:0] ST_WRBEAT = 3'd5;

  function automatic logic sz_legal(input logic [4:0] sz);
    return (sz <= 5'd7) || (sz == SZ_BURST16) || (sz == SZ_BURST32);
  endfunction

  // Index of the final beat; illegal codes are treated as a single beat.
  function automatic logic [1:0] last_beat(input logic [4:0] sz);
    if (sz == SZ_BURST32) return 2'd3;
    if (sz == SZ_BURST16) return 2'd1;
    return 2'd0;
  endfunction

  // Critical doubleword first, wrapping inside the 16/32-byte block.
  function automatic logic [28:0] beat_dword(input logic [31:0] addr,
                                             input logic [4:0]  sz,
                                             input logic [1:0]  beat);
    logic [1:0] off;
    off = addr[4:3] + beat;
    if (sz == SZ_BURST32) return {addr[31:5], off};
    if (sz == SZ_BURST16) return {addr[31:4], addr[3] ^ beat[0]};
    return addr[31:3];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ext_mem_responder_wlane.sv
// ----------------------------------------------------------------------------
// ext_wlane : big-endian byte-lane alignment of a right-justified single write
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ext_wlane (
  input  logic [2:0]  addr_lo_i,
  input  logic [2:0]  sz_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wmask_o
);

  logic [2:0] w_shift;
  logic [7:0] w_ones;

  // Only meaningful when addr_lo_i + sz_i <= 7; the caller rejects the rest.
  assign w_shift = 3'd7 - addr_lo_i - sz_i;
  assign w_ones  = 8'hFF >> (3'd7 - sz_i);
  assign wdata_o = wdata_i << {w_shift, 3'b000};
  assign wmask_o = w_ones << w_shift;

endmodule

`default_nettype wire

// File: rtl/ext_mem_responder.sv
// ----------------------------------------------------------------------------
// ext_mem_responder : single-transaction bridge from the ext bus to memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ext_mem_responder #(
  parameter logic [31:0] MEMBYTES = 32'h0080_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] extaddr,
  input  logic [63:0] extwdata,
  input  logic [4:0]  extsz,
  input  logic        extreq,
  input  logic        extwr,
  input  logic        extsrc,
  output logic        extrdy,
  output logic        extreply,
  output logic        extreplyto,
  output logic [63:0] extrdata,
  output logic        exterror,
  output logic [28:0] memaddr,
  output logic        memrd,
  output logic        memwr,
  output logic [63:0] memwdata,
  output logic [7:0]  memwmask,
  input  logic        memack,
  input  logic        memrvalid,
  input  logic [63:0] memrdata
);

  import ext_mem_responder_pkg::*;

  logic [2:0]  state_q,   state_d;
  logic [31:0] addr_q,    addr_d;
  logic [4:0]  sz_q,      sz_d;
  logic        src_q,     src_d;
  logic [63:0] wdata_q,   wdata_d;
  logic [1:0]  beat_q,    beat_d;
  logic        reply_q,   reply_d;
  logic        error_q,   error_d;
  logic        replyto_q, replyto_d;
  logic [63:0] rdata_q,   rdata_d;

  logic        w_last;
  logic        w_burst;
  logic        w_in_range;
  logic        w_span_ok;
  logic [63:0] w_lane_data;
  logic [7:0]  w_lane_mask;

  ext_wlane u_wlane (
    .addr_lo_i (addr_q[2:0]),
    .sz_i      (sz_q[2:0]),
    .wdata_i   (wdata_q),
    .wdata_o   (w_lane_data),
    .wmask_o   (w_lane_mask)
  );

  assign w_last     = (beat_q == last_beat(sz_q));
  assign w_burst    = (sz_q == SZ_BURST16) || (sz_q == SZ_BURST32);
  assign w_in_range = (extaddr < MEMBYTES);
  assign w_span_ok  = (extsz > 5'd7) ||
                      (({1'b0, extaddr[2:0]} + {1'b0, extsz[2:0]}) <= 4'd7);

  assign extrdy     = !rst && ((state_q == ST_IDLE) || (state_q == ST_WRBEAT));
  assign extreply   = reply_q;
  assign exterror   = error_q;
  assign extreplyto = replyto_q;
  assign extrdata   = rdata_q;

  assign memaddr  = beat_dword(addr_q, sz_q, beat_q);
  assign memrd    = !rst && (state_q == ST_RDCMD);
  assign memwr    = !rst && (state_q == ST_WRCMD);
  assign memwdata = w_burst ? wdata_q : w_lane_data;
  assign memwmask = memwr ? (w_burst ? 8'hFF : w_lane_mask) : 8'h00;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sz_d      = sz_q;
    src_d     = src_q;
    wdata_d   = wdata_q;
    beat_d    = beat_q;
    reply_d   = 1'b0;
    error_d   = 1'b0;
    replyto_d = replyto_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (extreq) begin
          addr_d  = extaddr;
          sz_d    = extsz;
          src_d   = extsrc;
          wdata_d = extwdata;
          beat_d  = 2'd0;
          if (extwr) begin
            state_d = (sz_legal(extsz) && w_in_range && w_span_ok) ? ST_WRCMD : ST_IDLE;
          end else begin
            state_d = (sz_legal(extsz) && w_in_range) ? ST_RDCMD : ST_ERRREP;
          end
        end
      end
      ST_RDCMD: begin
        if (memack) state_d = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        if (memrvalid) begin
          reply_d   = 1'b1;
          rdata_d   = memrdata;
          replyto_d = src_q;
          if (w_last) begin
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = ST_RDCMD;
          end
        end
      end
      ST_ERRREP: begin
        reply_d   = 1'b1;
        error_d   = 1'b1;
        rdata_d   = 64'd0;
        replyto_d = src_q;
        if (w_last) begin
          state_d = ST_IDLE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      ST_WRCMD: begin
        if (memack) begin
          if (w_last) begin
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = ST_WRBEAT;
          end
        end
      end
      ST_WRBEAT: begin
        if (extreq) begin
          wdata_d = extwdata;
          state_d = ST_WRCMD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'd0;
      sz_q      <= 5'd0;
      src_q     <= 1'b0;
      wdata_q   <= 64'd0;
      beat_q    <= 2'd0;
      reply_q   <= 1'b0;
      error_q   <= 1'b0;
      replyto_q <= 1'b0;
      rdata_q   <= 64'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sz_q      <= sz_d;
      src_q     <= src_d;
      wdata_q   <= wdata_d;
      beat_q    <= beat_d;
      reply_q   <= reply_d;
      error_q   <= error_d;
      replyto_q <= replyto_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

`default_nettype wire
